// File: rtl/europa_lpddr_perf_pkg.sv
// rtl/europa_lpddr_perf_pkg.sv - shared types and defaults for the LPDDR performance counter bank
// Purpose: default parameter values, select width and value/delta typedefs
//          used by the counter bank and its per-channel sub-module.
package europa_lpddr_perf_pkg;

    localparam int PerfDefNumCounters  = 4;
    localparam int PerfDefNumEvents    = 8;
    localparam int PerfDefCounterWidth = 32;
    localparam int PerfDefDeltaWidth   = 4;

    localparam int PerfSelWidth = $clog2(PerfDefNumEvents);

    typedef logic [PerfDefCounterWidth-1:0] perf_cnt_t;
    typedef logic [PerfDefDeltaWidth-1:0]   perf_delta_t;

endpackage

// File: rtl/europa_lpddr_perf_counter_chan.sv
// rtl/europa_lpddr_perf_counter_chan.sv - one performance counter channel
// Purpose: stage-1 event mux register, stage-2 accumulator with wrap or
//          saturate, sticky overflow / threshold flags, snapshot register.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_event_delta         all event deltas, flattened NumEvents x DeltaWidth
//   i_cfg_en/sel          count enable and event select (sampled at stage 1)
//   i_cfg_saturate        wrap/saturate mode (sampled at stage 2)
//   i_cfg_threshold       threshold, 0 disables
//   i_flush, i_snapshot   clear pulse, capture pulse
//   o_value, o_snapshot   live and captured counter value
//   o_overflow            sticky overflow/saturation flag
//   o_thresh_hit          sticky threshold-crossing flag
module europa_lpddr_perf_counter_chan
    import europa_lpddr_perf_pkg::*;
#(
    parameter int NumEvents    = PerfDefNumEvents,
    parameter int CounterWidth = PerfDefCounterWidth,
    parameter int DeltaWidth   = PerfDefDeltaWidth,
    parameter int SelWidth     = $clog2(NumEvents)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NumEvents*DeltaWidth-1:0] i_event_delta,
    input  logic                            i_cfg_en,
    input  logic [SelWidth-1:0]             i_cfg_sel,
    input  logic                            i_cfg_saturate,
    input  logic [CounterWidth-1:0]         i_cfg_threshold,
    input  logic                            i_flush,
    input  logic                            i_snapshot,
    output logic [CounterWidth-1:0]         o_value,
    output logic [CounterWidth-1:0]         o_snapshot,
    output logic                            o_overflow,
    output logic                            o_thresh_hit
);

    logic [DeltaWidth-1:0]   delta_d, delta_q;
    logic [CounterWidth-1:0] cnt_d, cnt_q;
    logic [CounterWidth-1:0] snap_d, snap_q;
    logic                    ovf_d, ovf_q;
    logic                    hit_d, hit_q;
    logic [CounterWidth:0]   sum;

    // Explicit compare loop so a select beyond NumEvents simply matches nothing.
    always_comb begin
        delta_d = '0;
        if (i_cfg_en) begin
            for (int e = 0; e < NumEvents; e++) begin
                if (i_cfg_sel == SelWidth'(e)) begin
                    delta_d = i_event_delta[e*DeltaWidth +: DeltaWidth];
                end
            end
        end
    end

    assign sum = {1'b0, cnt_q} + {{(CounterWidth + 1 - DeltaWidth){1'b0}}, delta_q};

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        hit_d  = hit_q;
        snap_d = snap_q;
        // Snapshot takes the pre-update value, so a same-cycle flush is invisible to it.
        if (i_snapshot) begin
            snap_d = cnt_q;
        end
        if (i_flush) begin
            // The delta in stage 1 right now is dropped along with the count.
            cnt_d = '0;
            ovf_d = 1'b0;
            hit_d = 1'b0;
        end else begin
            if (sum[CounterWidth]) begin
                ovf_d = 1'b1;
                cnt_d = i_cfg_saturate ? '1 : sum[CounterWidth-1:0];
            end else begin
                cnt_d = sum[CounterWidth-1:0];
            end
            // Edge-triggered on the crossing, so raising the threshold under a
            // counter already above it does not fire.
            if ((i_cfg_threshold != '0) && (cnt_q < i_cfg_threshold)
                && (cnt_d >= i_cfg_threshold)) begin
                hit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            delta_q <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            delta_q <= delta_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
            hit_q   <= hit_d;
        end
    end

    assign o_value      = cnt_q;
    assign o_snapshot   = snap_q;
    assign o_overflow   = ovf_q;
    assign o_thresh_hit = hit_q;

endmodule

// File: rtl/europa_lpddr_perf_counter_bank.sv
// rtl/europa_lpddr_perf_counter_bank.sv - multi-channel LPDDR performance counter bank
// Purpose: NumCounters independent event counters with a shared atomic snapshot.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_event_delta         NumEvents x DeltaWidth per-cycle increments
//   i_cfg_*               per-counter enable, select, mode, threshold
//   i_flush               per-counter clear pulse
//   i_snapshot            global capture pulse
//   o_value, o_snapshot   NumCounters x CounterWidth live / captured values
//   o_snapshot_valid      one-cycle pulse after each capture
//   o_overflow            per-counter sticky overflow flag
//   o_thresh_hit          per-counter sticky threshold flag
module europa_lpddr_perf_counter_bank
    import europa_lpddr_perf_pkg::*;
#(
    parameter int NumCounters  = PerfDefNumCounters,
    parameter int NumEvents    = PerfDefNumEvents,
    parameter int CounterWidth = PerfDefCounterWidth,
    parameter int DeltaWidth   = PerfDefDeltaWidth
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NumEvents*DeltaWidth-1:0]         i_event_delta,
    input  logic [NumCounters-1:0]                  i_cfg_en,
    input  logic [NumCounters*$clog2(NumEvents)-1:0] i_cfg_sel,
    input  logic [NumCounters-1:0]                  i_cfg_saturate,
    input  logic [NumCounters*CounterWidth-1:0]     i_cfg_threshold,
    input  logic [NumCounters-1:0]                  i_flush,
    input  logic                                    i_snapshot,
    output logic [NumCounters*CounterWidth-1:0]     o_value,
    output logic [NumCounters*CounterWidth-1:0]     o_snapshot,
    output logic                                    o_snapshot_valid,
    output logic [NumCounters-1:0]                  o_overflow,
    output logic [NumCounters-1:0]                  o_thresh_hit
);

    localparam int SelWidth = $clog2(NumEvents);

    logic snap_valid_d, snap_valid_q;

    for (genvar k = 0; k < NumCounters; k++) begin : g_chan
        europa_lpddr_perf_counter_chan #(
            .NumEvents    (NumEvents),
            .CounterWidth (CounterWidth),
            .DeltaWidth   (DeltaWidth),
            .SelWidth     (SelWidth)
        ) u_chan (
            .i_clk           (i_clk),
            .i_rst           (i_rst),
            .i_event_delta   (i_event_delta),
            .i_cfg_en        (i_cfg_en[k]),
            .i_cfg_sel       (i_cfg_sel[k*SelWidth +: SelWidth]),
            .i_cfg_saturate  (i_cfg_saturate[k]),
            .i_cfg_threshold (i_cfg_threshold[k*CounterWidth +: CounterWidth]),
            .i_flush         (i_flush[k]),
            .i_snapshot      (i_snapshot),
            .o_value         (o_value[k*CounterWidth +: CounterWidth]),
            .o_snapshot      (o_snapshot[k*CounterWidth +: CounterWidth]),
            .o_overflow      (o_overflow[k]),
            .o_thresh_hit    (o_thresh_hit[k])
        );
    end

    assign snap_valid_d = i_snapshot;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_valid_d;
        end
    end

    assign o_snapshot_valid = snap_valid_q;

endmodule

// File: tb/tb_europa_lpddr_perf_counter_bank.sv
// tb/tb_europa_lpddr_perf_counter_bank.sv - self-checking bench for the performance counter bank
module tb_europa_lpddr_perf_counter_bank;

    localparam int NC = 4;
    localparam int NE = 6;
    localparam int CW = 8;
    localparam int DW = 4;
    localparam int SW = 3;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NE*DW-1:0]   ev;
    logic [NC-1:0]      en, sat, flush;
    logic [NC*SW-1:0]   sel;
    logic [NC*CW-1:0]   thr;
    logic               snap;
    logic [NC*CW-1:0]   value, snapshot;
    logic               sv;
    logic [NC-1:0]      ov, th;

    int tests = 0;
    int fails = 0;

    // Reference state: one pending delta per counter, the count, flags, snapshot.
    int unsigned mcnt[NC], mpend[NC], msnap[NC];
    bit          mov[NC], mth[NC];
    bit          msv;

    always #5 clk = ~clk;

    europa_lpddr_perf_counter_bank #(
        .NumCounters(NC), .NumEvents(NE), .CounterWidth(CW), .DeltaWidth(DW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_event_delta(ev), .i_cfg_en(en), .i_cfg_sel(sel),
        .i_cfg_saturate(sat), .i_cfg_threshold(thr), .i_flush(flush), .i_snapshot(snap),
        .o_value(value), .o_snapshot(snapshot), .o_snapshot_valid(sv),
        .o_overflow(ov), .o_thresh_hit(th)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mcnt[k] = 0; mpend[k] = 0; msnap[k] = 0; mov[k] = 0; mth[k] = 0;
        end
        msv = 0;
    endtask

    task automatic check_all();
        for (int k = 0; k < NC; k++) begin
            chk($sformatf("value[%0d]", k), 32'(value[k*CW +: CW]), mcnt[k]);
            chk($sformatf("snapshot[%0d]", k), 32'(snapshot[k*CW +: CW]), msnap[k]);
            chk($sformatf("overflow[%0d]", k), 32'(ov[k]), 32'(mov[k]));
            chk($sformatf("thresh_hit[%0d]", k), 32'(th[k]), 32'(mth[k]));
        end
        chk("snapshot_valid", 32'(sv), 32'(msv));
    endtask

    task automatic set_ev(input int e, input int unsigned v);
        ev[e*DW +: DW] = v[DW-1:0];
    endtask

    function automatic int unsigned sel_of(input int k);
        return int'(sel[k*SW +: SW]);
    endfunction

    // One clock: evaluate the counting rules on the inputs present now, then
    // compare everything after the edge.
    task automatic step();
        int unsigned ncnt[NC], npend[NC], nsnap[NC];
        bit          nov[NC], nth[NC];
        for (int k = 0; k < NC; k++) begin
            int unsigned s   = sel_of(k);
            int unsigned t   = thr[k*CW +: CW];
            int unsigned tot = mcnt[k] + mpend[k];
            npend[k] = (en[k] && s < NE) ? int'(ev[s*DW +: DW]) : 0;
            nsnap[k] = snap ? mcnt[k] : msnap[k];
            nov[k] = mov[k];
            nth[k] = mth[k];
            if (flush[k]) begin
                ncnt[k] = 0; nov[k] = 0; nth[k] = 0;
            end else begin
                if (tot > CMAX) begin
                    nov[k]  = 1;
                    ncnt[k] = sat[k] ? CMAX : tot - (CMAX + 1);
                end else begin
                    ncnt[k] = tot;
                end
                if (t != 0 && mcnt[k] < t && ncnt[k] >= t) nth[k] = 1;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NC; k++) begin
            mcnt[k] = ncnt[k]; mpend[k] = npend[k]; msnap[k] = nsnap[k];
            mov[k] = nov[k]; mth[k] = nth[k];
        end
        msv = snap;
        check_all();
    endtask

    initial begin
        int unsigned pre[NC];
        en = '0; sat = '0; flush = '0; sel = '0; thr = '0; snap = 1'b0; ev = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_value_all", value, 32'd0);
        rst = 1'b0;

        // Basic count: counter 0 on event 2, delta 3 x10
        sel[0*SW +: SW] = 3'd2; en[0] = 1'b1; set_ev(2, 3);
        step(); chk("latency_n1", 32'(value[7:0]), 32'd0);
        step(); chk("latency_n2", 32'(value[7:0]), 32'd3);
        repeat (8) step();
        ev = '0;
        repeat (2) step();
        chk("basic_30", 32'(value[7:0]), 32'd30);
        en[0] = 1'b0;

        // Wrap: counter 1 to 250, then +10
        en[1] = 1'b1; sel[1*SW +: SW] = 3'd0; set_ev(0, 10);
        repeat (26) step();
        ev = '0;
        repeat (2) step();
        chk("wrap_value", 32'(value[15:8]), 32'd4);
        chk("wrap_ovf", 32'(ov[1]), 32'd1);

        // Saturate: same stimulus after a flush
        flush[1] = 1'b1; step(); flush = '0;
        chk("flush_value", 32'(value[15:8]), 32'd0);
        chk("flush_ovf", 32'(ov[1]), 32'd0);
        sat[1] = 1'b1; set_ev(0, 10);
        repeat (26) step();
        ev = '0;
        repeat (2) step();
        chk("sat_value", 32'(value[15:8]), 32'd255);
        chk("sat_ovf", 32'(ov[1]), 32'd1);
        sat[1] = 1'b0; en[1] = 1'b0;

        // Threshold 100 with delta 7
        en[2] = 1'b1; sel[2*SW +: SW] = 3'd3; thr[2*CW +: CW] = 8'd100; set_ev(3, 7);
        repeat (15) step();
        chk("thr_value_98", 32'(value[23:16]), 32'd98);
        chk("thr_not_yet", 32'(th[2]), 32'd0);
        ev = '0;
        step();
        chk("thr_value_105", 32'(value[23:16]), 32'd105);
        chk("thr_hit", 32'(th[2]), 32'd1);

        // Threshold 0 never fires, even across a wrap
        en = 4'b1000; sel[3*SW +: SW] = 3'd4; set_ev(4, 15);
        repeat (40) step();
        ev = '0;
        repeat (2) step();
        chk("thr0_value", 32'(value[31:24]), 32'd88);
        chk("thr0_ovf", 32'(ov[3]), 32'd1);
        chk("thr0_no_hit", 32'(th[3]), 32'd0);

        // Out-of-range select contributes nothing
        sel[3*SW +: SW] = 3'd6; ev = '1;
        repeat (3) step();
        chk("oor_sel", 32'(value[31:24]), 32'd88);

        // Atomic snapshot with a same-cycle flush on counter 1
        en = '1; sel = {3'd5, 3'd3, 3'd2, 3'd1};
        repeat (5) begin ev = (NE*DW)'($urandom); step(); end
        for (int k = 0; k < NC; k++) pre[k] = mcnt[k];
        snap = 1'b1; flush[1] = 1'b1;
        step();
        for (int k = 0; k < NC; k++)
            chk($sformatf("snap_pre[%0d]", k), 32'(snapshot[k*CW +: CW]), pre[k]);
        chk("snap_valid", 32'(sv), 32'd1);
        chk("snap_flush_zero", 32'(value[15:8]), 32'd0);
        snap = 1'b0; flush = '0;
        step();
        chk("snap_valid_drop", 32'(sv), 32'd0);
        snap = 1'b1; step(); chk("b2b_valid_1", 32'(sv), 32'd1);
        step(); chk("b2b_valid_2", 32'(sv), 32'd1);
        snap = 1'b0; step(); chk("b2b_valid_end", 32'(sv), 32'd0);

        // Flush while delta 5 sits in stage 1
        en = 4'b0010; sel[1*SW +: SW] = 3'd0; ev = '0; set_ev(0, 5);
        step();
        ev = '0; flush[1] = 1'b1;
        step();
        chk("fvi_zero", 32'(value[15:8]), 32'd0);
        flush = '0; set_ev(0, 5);
        step();
        ev = '0;
        step();
        chk("fvi_five", 32'(value[15:8]), 32'd5);

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            ev    = (NE*DW)'($urandom);
            flush = ($urandom_range(0, 15) == 0) ? NC'($urandom) : '0;
            snap  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) begin
                en  = NC'($urandom);
                sel = (NC*SW)'($urandom);
                sat = NC'($urandom);
                thr = (NC*CW)'($urandom);
            end
            step();
        end

        // Asynchronous reset between edges, then resume
        flush = '0; snap = 1'b0; sat = '0; thr = '0;
        en = 4'b0001; sel[0*SW +: SW] = 3'd2; ev = '0; set_ev(2, 3);
        step(); step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_async_value", value, 32'd0);
        chk("rst_async_flags", 32'({ov, th, sv}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rst_resume_0", 32'(value[7:0]), 32'd0);
        step();
        chk("rst_resume_3", 32'(value[7:0]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
